npu_csr_axil: RTL and testbench

AXI-Lite slave register file that implements the NPU control/status register map on behalf of the host. It terminates host AXI-Lite transactions and decodes them into enables, configuration and single-cycle start/clear strobes for the NPU core. It also folds core busy/done/error indications back into a readable STATUS word. It sits between the SoC interconnect and the NPU top-level controller.

---
 rtl/npu_csr_axil.sv | 237 +++++++++++++++++++++++
 tb/tb_npu_csr_axil.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_csr_axil.sv
// npu_csr_axil: AXI-Lite control/status register file for the NPU core.
// Terminates host writes/reads, drives enables/config and start/clear strobes,
// and folds core busy/done/error back into a readable STATUS word.
module npu_csr_axil #(
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_wdata,
    input  logic [3:0]                  s_wstrb,
    output logic                        s_bvalid,
    input  logic                        s_bready,
    output logic [1:0]                  s_bresp,
    input  logic                        s_arvalid,
    output logic                        s_arready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
    output logic                        s_rvalid,
    input  logic                        s_rready,
    output logic [AXI_DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        start_o,
    output logic                        clear_o,
    output logic [3:0]                  cluster_en_o,
    output logic [15:0]                 pe_en_o,
    output logic [31:0]                 config_o,
    input  logic                        busy_i,
    input  logic                        done_i,
    input  logic                        error_i
);

    typedef enum logic [2:0] {
        REG_CTRL    = 3'd0,
        REG_STATUS  = 3'd1,
        REG_CLUSTER = 3'd2,
        REG_PE0     = 3'd3,
        REG_PE1     = 3'd4,
        REG_PE2     = 3'd5,
        REG_PE3     = 3'd6,
        REG_CONFIG  = 3'd7
    } reg_idx_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                          aw_held_q, aw_held_d;
    logic [AXI_ADDR_WIDTH-1:2]     awaddr_q, awaddr_d;
    logic                          w_held_q, w_held_d;
    logic [AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [3:0]                    wstrb_q, wstrb_d;
    logic                          bvalid_q, bvalid_d;
    logic [1:0]                    bresp_q, bresp_d;
    logic                          rvalid_q, rvalid_d;
    logic [AXI_DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [1:0]                    rresp_q, rresp_d;
    logic [3:0]                    cluster_en_q, cluster_en_d;
    logic [15:0]                   pe_en_q, pe_en_d;
    logic [31:0]                   config_q, config_d;
    logic                          done_q, done_d;
    logic                          error_q, error_d;
    logic                          start_q, start_d;
    logic                          clear_q, clear_d;

    logic                          aw_hs, w_hs, commit, ar_hs;
    logic [AXI_ADDR_WIDTH-1:2]     wr_addr;
    logic [AXI_DATA_WIDTH-1:0]     wr_data;
    logic [3:0]                    wr_strb;
    logic                          wr_mapped, rd_mapped;
    reg_idx_e                      wr_idx, rd_idx;
    logic                          ctrl_wr, ctrl_clear, start_req, start_ok, start_rej;
    logic                          unused_addr_bits;

    // Byte-lane address bits carry no meaning for word registers.
    assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

    assign s_awready    = !aw_held_q && !bvalid_q;
    assign s_wready     = !w_held_q && !bvalid_q;
    assign s_arready    = !rvalid_q;
    assign s_bvalid     = bvalid_q;
    assign s_bresp      = bresp_q;
    assign s_rvalid     = rvalid_q;
    assign s_rdata      = rdata_q;
    assign s_rresp      = rresp_q;
    assign start_o      = start_q;
    assign clear_o      = clear_q;
    assign cluster_en_o = cluster_en_q;
    assign pe_en_o      = pe_en_q;
    assign config_o     = config_q;

    // Write channel: capture AW and W independently, commit once both are present.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        aw_hs     = s_awvalid && s_awready;
        w_hs      = s_wvalid && s_wready;
        commit    = (aw_held_q || aw_hs) && (w_held_q || w_hs);
        wr_addr   = aw_held_q ? awaddr_q : s_awaddr[AXI_ADDR_WIDTH-1:2];
        wr_data   = w_held_q ? wdata_q : s_wdata;
        wr_strb   = w_held_q ? wstrb_q : s_wstrb;
        wr_mapped = (wr_addr[AXI_ADDR_WIDTH-1:5] == '0);
        wr_idx    = reg_idx_e'(wr_addr[4:2]);

        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_awaddr[AXI_ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_wdata;
            wstrb_d  = s_wstrb;
        end
        if (bvalid_q && s_bready) bvalid_d = 1'b0;
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_mapped ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Register file, control strobes and sticky status bits.
    always_comb begin
        ctrl_wr    = commit && wr_mapped && (wr_idx == REG_CTRL) && wr_strb[0];
        ctrl_clear = ctrl_wr && wr_data[1];
        start_req  = ctrl_wr && wr_data[0] && !wr_data[1];
        start_ok   = start_req && !busy_i;
        start_rej  = start_req && busy_i;

        cluster_en_d = cluster_en_q;
        pe_en_d      = pe_en_q;
        config_d     = config_q;
        start_d      = start_ok;
        clear_d      = ctrl_clear;
        done_d       = done_i || (done_q && !ctrl_clear && !start_ok);
        error_d      = error_i || start_rej || (error_q && !ctrl_clear);

        if (commit && wr_mapped) begin
            unique case (wr_idx)
                REG_CLUSTER: if (wr_strb[0]) cluster_en_d = wr_data[3:0];
                REG_PE0:     if (wr_strb[0]) pe_en_d[3:0]   = wr_data[3:0];
                REG_PE1:     if (wr_strb[0]) pe_en_d[7:4]   = wr_data[3:0];
                REG_PE2:     if (wr_strb[0]) pe_en_d[11:8]  = wr_data[3:0];
                REG_PE3:     if (wr_strb[0]) pe_en_d[15:12] = wr_data[3:0];
                REG_CONFIG: begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) config_d[8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

    // Read channel: decode against current (pre-commit) state on AR handshake.
    always_comb begin
        ar_hs     = s_arvalid && s_arready;
        rd_mapped = (s_araddr[AXI_ADDR_WIDTH-1:5] == '0);
        rd_idx    = reg_idx_e'(s_araddr[4:2]);
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        if (rvalid_q && s_rready) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_mapped ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = '0;
            if (rd_mapped) begin
                unique case (rd_idx)
                    REG_STATUS:  rdata_d = AXI_DATA_WIDTH'({error_q, done_q, busy_i});
                    REG_CLUSTER: rdata_d = AXI_DATA_WIDTH'(cluster_en_q);
                    REG_PE0:     rdata_d = AXI_DATA_WIDTH'(pe_en_q[3:0]);
                    REG_PE1:     rdata_d = AXI_DATA_WIDTH'(pe_en_q[7:4]);
                    REG_PE2:     rdata_d = AXI_DATA_WIDTH'(pe_en_q[11:8]);
                    REG_PE3:     rdata_d = AXI_DATA_WIDTH'(pe_en_q[15:12]);
                    REG_CONFIG:  rdata_d = AXI_DATA_WIDTH'(config_q);
                    default:     rdata_d = '0;
                endcase
            end
        end
    end

    // State registers; reset drops holds, responses and pending strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_q    <= 1'b0;
            awaddr_q     <= '0;
            w_held_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            cluster_en_q <= 4'hF;
            pe_en_q      <= 16'hFFFF;
            config_q     <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            start_q      <= 1'b0;
            clear_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            aw_held_q    <= aw_held_d;
            awaddr_q     <= awaddr_d;
            w_held_q     <= w_held_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            cluster_en_q <= cluster_en_d;
            pe_en_q      <= pe_en_d;
            config_q     <= config_d;
            done_q       <= done_d;
            error_q      <= error_d;
            start_q      <= start_d;
            clear_q      <= clear_d;
        end
    end

endmodule

// File: tb/tb_npu_csr_axil.sv
// tb_npu_csr_axil: directed and randomized checks of the NPU CSR block
// against a register-map level reference model.
module tb_npu_csr_axil;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_awvalid, s_awready;
    logic [11:0] s_awaddr;
    logic        s_wvalid, s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;
    logic        s_arvalid, s_arready;
    logic [11:0] s_araddr;
    logic        s_rvalid, s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        start_o, clear_o;
    logic [3:0]  cluster_en_o;
    logic [15:0] pe_en_o;
    logic [31:0] config_o;
    logic        busy_i, done_i, error_i;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [3:0]  m_cluster;
    logic [3:0]  m_pe [4];
    logic [31:0] m_config;
    logic        m_done, m_err;
    logic        exp_start, exp_clear;
    logic        got_start0, got_start1, got_clear0, got_clear1;

    always #5 clk = ~clk;

    npu_csr_axil #(.AXI_ADDR_WIDTH(12), .AXI_DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .start_o(start_o), .clear_o(clear_o), .cluster_en_o(cluster_en_o),
        .pe_en_o(pe_en_o), .config_o(config_o),
        .busy_i(busy_i), .done_i(done_i), .error_i(error_i)
    );

    task automatic model_reset();
        m_cluster = 4'hF;
        for (int k = 0; k < 4; k++) m_pe[k] = 4'hF;
        m_config = 32'h0;
        m_done   = 1'b0;
        m_err    = 1'b0;
    endtask

    function automatic logic [1:0] model_resp(input logic [11:0] a);
        return (a < 12'h020) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        int idx;
        idx = int'(a) / 4;
        if (a >= 12'h020) return 32'h0;
        case (idx)
            1:       return {29'd0, m_err, m_done, busy_i};
            2:       return {28'd0, m_cluster};
            3, 4, 5, 6: return {28'd0, m_pe[idx-3]};
            7:       return m_config;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] st);
        int idx;
        idx = int'(a) / 4;
        exp_start = 1'b0;
        exp_clear = 1'b0;
        if (a >= 12'h020) return;
        case (idx)
            0: if (st[0]) begin
                if (d[1]) begin
                    exp_clear = 1'b1; m_done = 1'b0; m_err = 1'b0;
                end else if (d[0]) begin
                    if (busy_i) m_err = 1'b1;
                    else begin exp_start = 1'b1; m_done = 1'b0; end
                end
            end
            2: if (st[0]) m_cluster = d[3:0];
            3, 4, 5, 6: if (st[0]) m_pe[idx-3] = d[3:0];
            7: for (int b = 0; b < 4; b++) if (st[b]) m_config[8*b +: 8] = d[8*b +: 8];
            default: ;
        endcase
    endtask

    // Full write: AW offered from cycle aw_at, W from cycle w_at (relative to start).
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] st,
                             input int aw_at, input int w_at, input bit wait_b,
                             output logic [1:0] resp);
        bit awd = 0, wd = 0, afire, wfire;
        int c = 0;
        while (!(awd && wd)) begin
            s_awvalid = !awd && (c >= aw_at);
            s_awaddr  = a;
            s_wvalid  = !wd && (c >= w_at);
            s_wdata   = d;
            s_wstrb   = st;
            @(negedge clk);
            afire = s_awvalid && s_awready;
            wfire = s_wvalid && s_wready;
            @(posedge clk); #1;
            awd = awd || afire;
            wd  = wd || wfire;
            c++;
            if (!(awd && wd)) begin
                total++;
                if (s_bvalid !== 1'b0) begin
                    bad++; $display("FAIL bvalid_early addr=%h got=%b want=0", a, s_bvalid);
                end
            end
            if (c > 50) begin
                total++; bad++;
                $display("FAIL write_timeout addr=%h got=stalled want=handshake", a);
                break;
            end
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        model_write(a, d, st);
        resp = s_bresp;
        got_start0 = start_o;
        got_clear0 = clear_o;
        total++;
        if (s_bvalid !== 1'b1) begin
            bad++; $display("FAIL bvalid_at_commit addr=%h got=%b want=1", a, s_bvalid);
        end
        total++;
        if (s_bresp !== model_resp(a)) begin
            bad++; $display("FAIL bresp addr=%h got=%b want=%b", a, s_bresp, model_resp(a));
        end
        total++;
        if ({cluster_en_o, pe_en_o, config_o} !== {m_cluster, m_pe[3], m_pe[2], m_pe[1], m_pe[0], m_config}) begin
            bad++;
            $display("FAIL reg_outputs addr=%h got=%h_%h_%h want=%h_%h%h%h%h_%h", a, cluster_en_o, pe_en_o,
                     config_o, m_cluster, m_pe[3], m_pe[2], m_pe[1], m_pe[0], m_config);
        end
        if (wait_b) begin
            @(posedge clk); #1;
            got_start1 = start_o;
            got_clear1 = clear_o;
            total++;
            if (s_bvalid !== 1'b0) begin
                bad++; $display("FAIL bvalid_release addr=%h got=%b want=0", a, s_bvalid);
            end
            total++;
            if ({got_start0, got_start1, got_clear0, got_clear1} !== {exp_start, 1'b0, exp_clear, 1'b0}) begin
                bad++;
                $display("FAIL strobes addr=%h got=%b%b/%b%b want=%b0/%b0", a, got_start0, got_start1,
                         got_clear0, got_clear1, exp_start, exp_clear);
            end
        end
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] data, output logic [1:0] resp);
        bit fire;
        int c = 0;
        logic [31:0] want;
        want = model_read(a);
        s_arvalid = 1'b1;
        s_araddr  = a;
        forever begin
            @(negedge clk);
            fire = s_arready;
            @(posedge clk); #1;
            c++;
            if (fire) break;
            if (c > 50) begin
                total++; bad++;
                $display("FAIL read_timeout addr=%h got=stalled want=handshake", a);
                break;
            end
        end
        s_arvalid = 1'b0;
        data = s_rdata;
        resp = s_rresp;
        total++;
        if ({s_rvalid, s_rdata, s_rresp} !== {1'b1, want, model_resp(a)}) begin
            bad++;
            $display("FAIL read addr=%h got=v%b d=%h r=%b want=v1 d=%h r=%b", a, s_rvalid, s_rdata,
                     s_rresp, want, model_resp(a));
        end
        if (s_rready) begin
            @(posedge clk); #1;
            total++;
            if (s_rvalid !== 1'b0) begin
                bad++; $display("FAIL rvalid_release addr=%h got=%b want=0", a, s_rvalid);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        rst_n = 1'b0;
        s_awvalid = 0; s_awaddr = 0; s_wvalid = 0; s_wdata = 0; s_wstrb = 0;
        s_arvalid = 0; s_araddr = 0; s_bready = 1; s_rready = 1;
        busy_i = 0; done_i = 0; error_i = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({s_bvalid, s_rvalid, start_o, clear_o, cluster_en_o, pe_en_o, config_o, s_rdata, s_bresp, s_rresp}
            !== {4'b0000, 4'hF, 16'hFFFF, 32'h0, 32'h0, 2'b00, 2'b00}) begin
            bad++;
            $display("FAIL reset_values got=%b%b%b%b %h %h %h want=0000 f ffff 00000000", s_bvalid,
                     s_rvalid, start_o, clear_o, cluster_en_o, pe_en_o, config_o);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            bad++; $display("FAIL reset_ready got=%b%b%b want=111", s_awready, s_wready, s_arready);
        end
        for (int i = 0; i < 8; i++) axi_read(12'(i * 4), d, r);
    endtask

    task automatic test_aw_first();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(12'h008, 32'h5, 4'hF, 0, 3, 1, r);
        total++;
        if (cluster_en_o !== 4'b0101) begin
            bad++; $display("FAIL aw_first_cluster got=%b want=0101", cluster_en_o);
        end
        axi_read(12'h008, d, r);
        total++;
        if (d !== 32'h5) begin
            bad++; $display("FAIL aw_first_readback got=%h want=00000005", d);
        end
        axi_write(12'h00C, 32'hA, 4'hF, 2, 0, 1, r);
    endtask

    task automatic test_wstrb();
        logic [1:0] r;
        axi_write(12'h01C, 32'hAABBCCDD, 4'hF, 0, 0, 1, r);
        axi_write(12'h01F, 32'h11223344, 4'b0101, 1, 0, 1, r);
        total++;
        if (config_o !== 32'hAA22CC44) begin
            bad++; $display("FAIL wstrb_config got=%h want=aa22cc44", config_o);
        end
        axi_write(12'h014, 32'hFFFF_FFF3, 4'b1110, 0, 0, 1, r);
    endtask

    task automatic test_ctrl();
        logic [1:0]  r;
        logic [31:0] d;
        busy_i = 1'b0;
        axi_write(12'h000, 32'h1, 4'hF, 0, 0, 1, r);
        total++;
        if ({got_start0, got_start1} !== 2'b10) begin
            bad++; $display("FAIL ctrl_start_pulse got=%b%b want=10", got_start0, got_start1);
        end
        busy_i = 1'b1;
        axi_write(12'h000, 32'h1, 4'hF, 0, 0, 1, r);
        axi_read(12'h004, d, r);
        total++;
        if (d !== 32'h5) begin
            bad++; $display("FAIL status_busy_err got=%h want=00000005", d);
        end
        done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
        m_done = 1'b1;
        busy_i = 1'b0;
        axi_read(12'h004, d, r);
        total++;
        if (d !== 32'h6) begin
            bad++; $display("FAIL status_done_err got=%h want=00000006", d);
        end
        axi_write(12'h000, 32'h2, 4'hF, 0, 0, 1, r);
        axi_read(12'h004, d, r);
        total++;
        if (d !== 32'h0) begin
            bad++; $display("FAIL status_after_clear got=%h want=00000000", d);
        end
        axi_write(12'h000, 32'h3, 4'hF, 0, 0, 1, r);
        axi_write(12'h000, 32'h1, 4'hE, 0, 0, 1, r);
        error_i = 1'b1;
        @(posedge clk); #1;
        error_i = 1'b0;
        m_err = 1'b1;
        axi_read(12'h004, d, r);
        axi_write(12'h004, 32'hFFFF_FFFF, 4'hF, 0, 0, 1, r);
        axi_read(12'h000, d, r);
        axi_write(12'h000, 32'h2, 4'hF, 0, 0, 1, r);
    endtask

    task automatic test_unmapped();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(12'h020, 32'hDEADBEEF, 4'hF, 0, 0, 1, r);
        total++;
        if (r !== 2'b10) begin
            bad++; $display("FAIL unmapped_bresp got=%b want=10", r);
        end
        axi_read(12'h100, d, r);
        total++;
        if ({d, r} !== {32'h0, 2'b10}) begin
            bad++; $display("FAIL unmapped_read got=%h/%b want=00000000/10", d, r);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]  r;
        logic [31:0] d;
        s_bready = 1'b0;
        axi_write(12'h010, 32'h9, 4'hF, 0, 0, 0, r);
        axi_read(12'h01C, d, r);
        total++;
        if (r !== 2'b00) begin
            bad++; $display("FAIL concurrent_read_resp got=%b want=00", r);
        end
        repeat (5) begin
            @(posedge clk); #1;
            total++;
            if ({s_bvalid, s_awready, s_wready} !== 3'b100) begin
                bad++; $display("FAIL bp_hold got=%b%b%b want=100", s_bvalid, s_awready, s_wready);
            end
        end
        s_bready = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({s_bvalid, s_awready, s_wready} !== 3'b011) begin
            bad++; $display("FAIL bp_release got=%b%b%b want=011", s_bvalid, s_awready, s_wready);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r;
        s_awvalid = 1'b1;
        s_awaddr  = 12'h01C;
        @(negedge clk);
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if ({s_bvalid, s_awready, start_o, clear_o} !== 4'b0100) begin
            bad++; $display("FAIL reset_mid got=%b%b%b%b want=0100", s_bvalid, s_awready, start_o, clear_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi_write(12'h008, 32'h3, 4'hF, 2, 0, 1, r);
    endtask

    task automatic test_random();
        logic [11:0] a;
        logic [31:0] d;
        logic [1:0]  r;
        busy_i = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) a = 12'h100;
            else a = 12'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                          $urandom_range(0, 2), 1, r);
            else
                axi_read(a, d, r);
        end
    endtask

    initial begin
        test_reset();
        test_aw_first();
        test_wstrb();
        test_ctrl();
        test_unmapped();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
